// File: rtl/mdu_iter_pkg.sv
// Shared opcodes, FSM state type and sizing helper for the iterative multiply/divide unit.
package mdu_iter_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MFHI  = 4'd5;
  localparam logic [3:0] MDU_MFLO  = 4'd6;
  localparam logic [3:0] MDU_MTHI  = 4'd7;
  localparam logic [3:0] MDU_MTLO  = 4'd8;
  localparam logic [3:0] MDU_MADD  = 4'd9;
  localparam logic [3:0] MDU_MADDU = 4'd10;
  localparam logic [3:0] MDU_MSUB  = 4'd11;
  localparam logic [3:0] MDU_MSUBU = 4'd12;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MUL      = 2'd1,
    S_DIV_ITER = 2'd2,
    S_DIV_FIX  = 2'd3
  } mdu_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// E-stage issue bus of the multiply/divide unit.
// Handshake: an op is taken at a rising edge when start=1, cancel=0 and busy=0;
// the issuer must never raise start while busy=1 (stall keeps the op in D).
interface mdu_iter_if #(parameter int WIDTH = 32);
  logic             start;
  logic             cancel;
  logic [3:0]       op;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic             busy;
  logic [WIDTH-1:0] out;

  modport master (output start, cancel, op, rs, rt, input busy, out);
  modport slave  (input start, cancel, op, rs, rt, output busy, out);
endinterface

// File: rtl/mdu_div_step.sv
// One radix-2 restoring division iteration on unsigned magnitudes.
module mdu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem_in < divisor always holds, so the trial difference fits in WIDTH+1 bits.
    always_comb begin
        shifted = {rem_in, bit_in};
        diff    = shifted - {1'b0, divisor};
        q_bit   = ~diff[WIDTH];
        rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end
endmodule

// File: rtl/mdu_iter.sv
// Multi-cycle multiply/divide unit with HI/LO; bit-serial divider, fixed-latency multiply.
// Optional multiply-accumulate (MADD/MADDU/MSUB/MSUBU) is built when MDU_MACC_EN is defined.
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5
) (
    input  logic       clk,
    input  logic       reset,
    mdu_iter_if.slave  bus,
    output mdu_state_t dbg_state
);
    localparam int CW = $clog2(max_int(MUL_LAT, WIDTH) + 1);

    mdu_state_t         state_q, state_d;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic [2*WIDTH-1:0] res_q;
    logic [WIDTH-1:0]   rem_q, dvd_q, dsr_q;
    logic               sign_q_q, sign_r_q, dz_q;

    logic               accept, is_mul, mul_signed;
    logic [2*WIDTH-1:0] op_a, op_b, prod;
    logic [WIDTH-1:0]   step_rem;
    logic               step_q;
    logic               neg_rs, neg_rt;

    assign accept    = bus.start && !bus.cancel && (state_q == S_IDLE);
    assign bus.busy  = (state_q != S_IDLE);
    assign bus.out   = (bus.op == MDU_MFHI) ? hi_q : lo_q;
    assign dbg_state = state_q;

    always_comb begin
        is_mul     = (bus.op == MDU_MULT) || (bus.op == MDU_MULTU);
`ifdef MDU_MACC_EN
        is_mul     = is_mul || (bus.op == MDU_MADD) || (bus.op == MDU_MADDU) ||
                     (bus.op == MDU_MSUB) || (bus.op == MDU_MSUBU);
`endif
        mul_signed = (bus.op == MDU_MULT) || (bus.op == MDU_MADD) || (bus.op == MDU_MSUB);
        op_a       = mul_signed ? {{WIDTH{bus.rs[WIDTH-1]}}, bus.rs} : {{WIDTH{1'b0}}, bus.rs};
        op_b       = mul_signed ? {{WIDTH{bus.rt[WIDTH-1]}}, bus.rt} : {{WIDTH{1'b0}}, bus.rt};
        prod       = op_a * op_b;
        neg_rs     = (bus.op == MDU_DIV) && bus.rs[WIDTH-1];
        neg_rt     = (bus.op == MDU_DIV) && bus.rt[WIDTH-1];
    end

    mdu_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .bit_in  (dvd_q[WIDTH-1]),
        .divisor (dsr_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept && is_mul) state_d = S_MUL;
                else if (accept && ((bus.op == MDU_DIV) || (bus.op == MDU_DIVU)))
                    state_d = S_DIV_ITER;
            end
            S_MUL:      if (cnt_q == CW'(1)) state_d = S_IDLE;
            S_DIV_ITER: if (cnt_q == CW'(1)) state_d = S_DIV_FIX;
            S_DIV_FIX:  state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_q    <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            dsr_q    <= '0;
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (accept) begin
                    case (bus.op)
                        MDU_MTHI: hi_q <= bus.rs;
                        MDU_MTLO: lo_q <= bus.rs;
                        MDU_MULT, MDU_MULTU: begin
                            res_q <= prod;
                            cnt_q <= CW'(MUL_LAT);
                        end
`ifdef MDU_MACC_EN
                        MDU_MADD, MDU_MADDU: begin
                            res_q <= {hi_q, lo_q} + prod;
                            cnt_q <= CW'(MUL_LAT);
                        end
                        MDU_MSUB, MDU_MSUBU: begin
                            res_q <= {hi_q, lo_q} - prod;
                            cnt_q <= CW'(MUL_LAT);
                        end
`endif
                        MDU_DIV, MDU_DIVU: begin
                            rem_q    <= '0;
                            dvd_q    <= neg_rs ? -bus.rs : bus.rs;
                            dsr_q    <= neg_rt ? -bus.rt : bus.rt;
                            sign_q_q <= neg_rs ^ neg_rt;
                            sign_r_q <= neg_rs;
                            dz_q     <= (bus.rt == '0);
                            cnt_q    <= CW'(WIDTH);
                        end
                        default: ;
                    endcase
                end
                S_MUL: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) {hi_q, lo_q} <= res_q;
                end
                S_DIV_ITER: begin
                    rem_q <= step_rem;
                    dvd_q <= {dvd_q[WIDTH-2:0], step_q};
                    cnt_q <= cnt_q - CW'(1);
                end
                S_DIV_FIX: begin
                    // Divide by zero leaves rem=|rs|, so restoring its sign yields rs in HI.
                    hi_q <= sign_r_q ? -rem_q : rem_q;
                    lo_q <= dz_q ? '1 : (sign_q_q ? -dvd_q : dvd_q);
                end
                default: ;
            endcase
        end
    end

    a_no_start_busy: assert property (@(posedge clk) disable iff (!reset) !(bus.start && bus.busy))
        else $error("start raised while busy");
endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: vector table for multiply/divide plus hand sequences.
// Honours MDU_MACC_EN to select the expected accumulate behaviour.
module tb_mdu_iter;
  import mdu_iter_pkg::*;

  logic       clk;
  logic       reset;
  mdu_state_t dbg_state;
  int         checks;
  int         errors;

  mdu_iter_if #(.WIDTH(32)) bus();

  mdu_iter #(.WIDTH(32), .MUL_LAT(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic cancel);
    @(negedge clk);
    bus.op     = op;
    bus.rs     = rs;
    bus.rt     = rt;
    bus.cancel = cancel;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    bus.op     = MDU_NONE;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
      n++;
    end
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    bus.op = MDU_MFHI;
    #1;
    hi = bus.out;
    bus.op = MDU_MFLO;
    #1;
    lo = bus.out;
    bus.op = MDU_NONE;
  endtask

  initial begin
    logic [31:0] hi, lo;
    int          n;
    checks = 0;
    errors = 0;

    vecs[0] = '{MDU_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 5};
    vecs[1] = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[2] = '{MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
    vecs[3] = '{MDU_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       33};
    vecs[4] = '{MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    vecs[5] = '{MDU_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33};
    vecs[6] = '{MDU_DIV,   32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 33};
    vecs[7] = '{MDU_DIVU,  32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFF, 33};
    vecs[8] = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 33};

    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    bus.op     = MDU_NONE;
    bus.rs     = '0;
    bus.rt     = '0;
    reset      = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_state", 32'(dbg_state), 32'(S_IDLE));
    read_hilo(hi, lo);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].op, vecs[i].rs, vecs[i].rt, 1'b0);
      count_busy(n);
      check($sformatf("vec%0d_latency", i), 32'(n), 32'(vecs[i].lat));
      read_hilo(hi, lo);
      check($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
      check($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
    end

    // MTHI/MTLO and flush gating
    issue(MDU_MTHI, 32'h1234, 32'd0, 1'b0);
    @(negedge clk);
    check("mthi_busy", 32'(bus.busy), 32'd0);
    issue(MDU_MTLO, 32'hABCD, 32'd0, 1'b0);
    read_hilo(hi, lo);
    check("mthi_hi", hi, 32'h1234);
    check("mtlo_lo", lo, 32'hABCD);
    issue(MDU_MTHI, 32'h5678, 32'd0, 1'b1);
    read_hilo(hi, lo);
    check("mthi_cancel_hi", hi, 32'h1234);
    issue(MDU_MULT, 32'd3, 32'd3, 1'b1);
    count_busy(n);
    check("mult_cancel_busy", 32'(n), 32'd0);
    read_hilo(hi, lo);
    check("mult_cancel_hi", hi, 32'h1234);
    check("mult_cancel_lo", lo, 32'hABCD);

    // cancel asserted throughout an in-flight divide
    issue(MDU_DIVU, 32'd100, 32'd7, 1'b0);
    bus.cancel = 1'b1;
    count_busy(n);
    bus.cancel = 1'b0;
    check("cancel_div_latency", 32'(n), 32'd33);
    read_hilo(hi, lo);
    check("cancel_div_hi", hi, 32'd2);
    check("cancel_div_lo", lo, 32'd14);

    // asynchronous reset in the middle of a divide
    issue(MDU_DIV, 32'd1000, 32'd3, 1'b0);
    repeat (10) @(negedge clk);
    check("middiv_busy_before", 32'(bus.busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("middiv_busy", 32'(bus.busy), 32'd0);
    read_hilo(hi, lo);
    check("middiv_hi", hi, 32'd0);
    check("middiv_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    issue(MDU_MULTU, 32'd3, 32'd4, 1'b0);
    count_busy(n);
    check("post_reset_latency", 32'(n), 32'd5);
    read_hilo(hi, lo);
    check("post_reset_hi", hi, 32'd0);
    check("post_reset_lo", lo, 32'd12);

    // multiply-accumulate from HI=0, LO=all ones
    issue(MDU_MTHI, 32'd0, 32'd0, 1'b0);
    issue(MDU_MTLO, 32'hFFFFFFFF, 32'd0, 1'b0);
    issue(MDU_MADDU, 32'd1, 32'd1, 1'b0);
    count_busy(n);
    read_hilo(hi, lo);
`ifdef MDU_MACC_EN
    check("maddu_latency", 32'(n), 32'd5);
    check("maddu_hi", hi, 32'd1);
    check("maddu_lo", lo, 32'd0);
    issue(MDU_MSUB, 32'hFFFFFFFF, 32'd1, 1'b0);
    count_busy(n);
    read_hilo(hi, lo);
    check("msub_latency", 32'(n), 32'd5);
    check("msub_hi", hi, 32'd1);
    check("msub_lo", lo, 32'd1);
`else
    check("maddu_latency", 32'(n), 32'd0);
    check("maddu_hi", hi, 32'd0);
    check("maddu_lo", lo, 32'hFFFFFFFF);
    issue(MDU_MSUB, 32'hFFFFFFFF, 32'd1, 1'b0);
    count_busy(n);
    read_hilo(hi, lo);
    check("msub_latency", 32'(n), 32'd0);
    check("msub_hi", hi, 32'd0);
    check("msub_lo", lo, 32'hFFFFFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
